mem_copy_engine: RTL and testbench

Block-move initiator on the single-port data-memory interface: on a Start pulse it copies Length bytes from SrcAddr to DstAddr, or fills Length bytes with a constant, by driving the memory's address/write-enable/data-in port and sampling its combinational read data. It sits beside the core, and an external mux hands it the memory port while Busy is high. Every memory cycle is either a read or a write, never both, matching the memory's one-pointer-per-cycle rule.

---
 rtl/mem_copy_engine.sv | 148 ++++++++++++++
 tb/tb_mem_copy_engine.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// Block-move/fill initiator driving a single-port data memory, one read or write per cycle.
// Fill mode is compiled in only when MEMCPY_FILL_EN is defined; otherwise every transfer copies.
module mem_copy_engine #(
    parameter int unsigned W = 8,
    parameter int unsigned A = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [A-1:0] src_addr,
    input  logic [A-1:0] dst_addr,
    input  logic [A-1:0] length,
    input  logic         fill,
    input  logic [W-1:0] fill_value,
    input  logic [W-1:0] mem_data_in,
    output logic [A-1:0] mem_address,
    output logic         mem_write_en,
    output logic [W-1:0] mem_data_out,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } state_e;

    state_e       state_q, state_d;
    logic [A-1:0] src_q, src_d;
    logic [A-1:0] dst_q, dst_d;
    logic [A-1:0] count_q, count_d;
    logic [W-1:0] hold_q, hold_d;
    logic         fill_q, fill_d;
    logic [W-1:0] fill_val_q, fill_val_d;

    logic         fill_eff;
    logic [W-1:0] fill_value_eff;

`ifdef MEMCPY_FILL_EN
    assign fill_eff       = fill;
    assign fill_value_eff = fill_value;
`else
    // Ports stay so the top-level wiring is identical in both builds.
    logic unused_fill;
    assign unused_fill    = ^{fill, fill_value};
    assign fill_eff       = 1'b0;
    assign fill_value_eff = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            src_q      <= '0;
            dst_q      <= '0;
            count_q    <= '0;
            hold_q     <= '0;
            fill_q     <= 1'b0;
            fill_val_q <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            count_q    <= count_d;
            hold_q     <= hold_d;
            fill_q     <= fill_d;
            fill_val_q <= fill_val_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        count_d    = count_q;
        hold_d     = hold_q;
        fill_d     = fill_q;
        fill_val_d = fill_val_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    src_d      = src_addr;
                    dst_d      = dst_addr;
                    count_d    = length;
                    fill_d     = fill_eff;
                    fill_val_d = fill_value_eff;
                    if (length == '0) begin
                        state_d = StDone;
                    end else if (fill_eff) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                hold_d  = mem_data_in;
                src_d   = src_q + 1'b1;
                state_d = StWrite;
            end
            StWrite: begin
                dst_d   = dst_q + 1'b1;
                count_d = count_q - 1'b1;
                if (count_q == A'(1)) begin
                    state_d = StDone;
                end else if (fill_q) begin
                    state_d = StWrite;
                end else begin
                    state_d = StRead;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs depend on registered state only, never on the request inputs.
    always_comb begin
        mem_address  = '0;
        mem_write_en = 1'b0;
        mem_data_out = '0;
        busy         = (state_q != StIdle);
        done         = 1'b0;

        unique case (state_q)
            StRead: begin
                mem_address = src_q;
            end
            StWrite: begin
                mem_address  = dst_q;
                mem_write_en = 1'b1;
                mem_data_out = fill_q ? fill_val_q : hold_q;
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: behavioural memory, write scoreboard, latency checks.
// Expectations follow MEMCPY_FILL_EN the same way the design does.
module tb_mem_copy_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] src_addr = '0;
    logic [7:0] dst_addr = '0;
    logic [7:0] length = '0;
    logic       fill = 1'b0;
    logic [7:0] fill_value = '0;
    logic [7:0] mem_data_in;
    logic [7:0] mem_address;
    logic       mem_write_en;
    logic [7:0] mem_data_out;
    logic       busy;
    logic       done;

    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];
    logic [15:0] exp_q [$];
    int          errors = 0;
    int          checks = 0;
    int          wr_count = 0;

    always #5 clk = ~clk;

    mem_copy_engine #(.W(8), .A(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .length       (length),
        .fill         (fill),
        .fill_value   (fill_value),
        .mem_data_in  (mem_data_in),
        .mem_address  (mem_address),
        .mem_write_en (mem_write_en),
        .mem_data_out (mem_data_out),
        .busy         (busy),
        .done         (done)
    );

    assign mem_data_in = mem[mem_address];

    always @(posedge clk) begin
        if (mem_write_en === 1'b1) mem[mem_address] <= mem_data_out;
    end

    // Scoreboard: every observed write must match the oldest expected one.
    always @(negedge clk) begin
        if (mem_write_en === 1'b1) begin
            logic [15:0] e;
            wr_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h", mem_address, mem_data_out);
            end else begin
                e = exp_q.pop_front();
                if ({mem_address, mem_data_out} !== e) begin
                    errors++;
                    $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                             mem_address, mem_data_out, e[15:8], e[7:0]);
                end
            end
        end
    end

    function automatic void push_expected(input logic [7:0] src, input logic [7:0] dst,
                                          input logic [7:0] len, input logic fl,
                                          input logic [7:0] fv);
        logic       eff_fill;
        logic [7:0] s, d, v;
        eff_fill = fl;
`ifndef MEMCPY_FILL_EN
        eff_fill = 1'b0;
`endif
        for (int k = 0; k < int'(len); k++) begin
            s = src + 8'(k);
            d = dst + 8'(k);
            v = eff_fill ? fv : ref_mem[s];
            ref_mem[d] = v;
            exp_q.push_back({d, v});
        end
    endfunction

    function automatic int count_diffs();
        int n = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    // Drives one request, scrambles the request inputs after acceptance, and measures timing.
    task automatic run_xfer(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len,
                            input logic fl, input logic [7:0] fv,
                            output int done_at, output logic busy1, output logic idle_busy);
        int i;
        @(negedge clk);
        src_addr = src; dst_addr = dst; length = len; fill = fl; fill_value = fv;
        start = 1'b1;
        push_expected(src, dst, len, fl, fv);
        wr_count = 0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        src_addr = 8'($urandom); dst_addr = 8'($urandom); length = 8'($urandom);
        fill = ~fl; fill_value = 8'($urandom);
        busy1 = busy;
        done_at = -1;
        i = 1;
        while (i <= 600) begin
            if (done === 1'b1) begin
                done_at = i;
                break;
            end
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        idle_busy = busy;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({busy, done, mem_write_en, mem_address, mem_data_out} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b we=%b addr=%h data=%h want all 0",
                     busy, done, mem_write_en, mem_address, mem_data_out);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_held got busy=%b done=%b want 0 0", busy, done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b want 0", busy);
        end
    endtask

    task automatic test_copy();
        int da; logic b1, ib;
        run_xfer(8'h10, 8'h40, 8'd4, 1'b0, 8'h00, da, b1, ib);
        checks++;
        if (da !== 9) begin errors++; $display("FAIL copy_latency got=%0d want=9", da); end
        checks++;
        if (wr_count !== 4) begin errors++; $display("FAIL copy_writes got=%0d want=4", wr_count); end
        checks++;
        if (b1 !== 1'b1 || ib !== 1'b0) begin
            errors++;
            $display("FAIL copy_busy got first=%b after=%b want 1 0", b1, ib);
        end
        checks++;
        if ({mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]} !== 32'hAABBCCDD) begin
            errors++;
            $display("FAIL copy_data got=%h want=aabbccdd",
                     {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]});
        end
        checks++;
        if (count_diffs() !== 0) begin
            errors++; $display("FAIL copy_memory got=%0d differing bytes want=0", count_diffs());
        end
    endtask

    task automatic test_zero_len();
        int da; logic b1, ib;
        run_xfer(8'h10, 8'h50, 8'd0, 1'b0, 8'h00, da, b1, ib);
        checks++;
        if (da !== 1) begin errors++; $display("FAIL zero_latency got=%0d want=1", da); end
        checks++;
        if (wr_count !== 0) begin errors++; $display("FAIL zero_writes got=%0d want=0", wr_count); end
        checks++;
        if (count_diffs() !== 0) begin
            errors++; $display("FAIL zero_memory got=%0d differing bytes want=0", count_diffs());
        end
    endtask

    task automatic test_wrap();
        int da; logic b1, ib;
        run_xfer(8'hFE, 8'h7E, 8'd4, 1'b0, 8'h00, da, b1, ib);
        checks++;
        if (da !== 9) begin errors++; $display("FAIL wrap_latency got=%0d want=9", da); end
        checks++;
        if ({mem[8'h7E], mem[8'h7F], mem[8'h80], mem[8'h81]} !== 32'hA4A55A5B) begin
            errors++;
            $display("FAIL wrap_data got=%h want=a4a55a5b",
                     {mem[8'h7E], mem[8'h7F], mem[8'h80], mem[8'h81]});
        end
    endtask

    task automatic test_fill();
        int da; logic b1, ib;
        logic [23:0] want_data;
        int want_lat;
`ifdef MEMCPY_FILL_EN
        want_data = 24'h202020; want_lat = 4;
`else
        want_data = 24'hAABBCC; want_lat = 7;
`endif
        run_xfer(8'h10, 8'h80, 8'd3, 1'b1, 8'h20, da, b1, ib);
        checks++;
        if (da !== want_lat) begin
            errors++; $display("FAIL fill_latency got=%0d want=%0d", da, want_lat);
        end
        checks++;
        if ({mem[8'h80], mem[8'h81], mem[8'h82]} !== want_data) begin
            errors++;
            $display("FAIL fill_data got=%h want=%h", {mem[8'h80], mem[8'h81], mem[8'h82]},
                     want_data);
        end
        checks++;
        if (wr_count !== 3) begin errors++; $display("FAIL fill_writes got=%0d want=3", wr_count); end
    endtask

    task automatic test_overlap();
        int da; logic b1, ib;
        run_xfer(8'h10, 8'h11, 8'd3, 1'b0, 8'h00, da, b1, ib);
        checks++;
        if ({mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]} !== 32'hAAAAAAAA) begin
            errors++;
            $display("FAIL overlap_data got=%h want=aaaaaaaa",
                     {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]});
        end
        checks++;
        if (count_diffs() !== 0) begin
            errors++; $display("FAIL overlap_memory got=%0d differing bytes want=0", count_diffs());
        end
    endtask

    task automatic test_reset_mid();
        int da; logic b1, ib;
        int done_seen = 0;
        @(negedge clk);
        src_addr = 8'h20; dst_addr = 8'h60; length = 8'd8; fill = 1'b0; start = 1'b1;
        ref_mem[8'h60] = ref_mem[8'h20];
        exp_q.push_back({8'h60, ref_mem[8'h20]});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, mem_write_en, mem_address, mem_data_out} !== 19'd0) begin
            errors++;
            $display("FAIL midreset_outputs got busy=%b done=%b we=%b addr=%h data=%h want all 0",
                     busy, done, mem_write_en, mem_address, mem_data_out);
        end
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++; $display("FAIL midreset_done got=%0d pulses want=0", done_seen);
        end
        checks++;
        if (exp_q.size() !== 0 || count_diffs() !== 0) begin
            errors++;
            $display("FAIL midreset_memory got pending=%0d diffs=%0d want 0 0",
                     exp_q.size(), count_diffs());
        end
        exp_q.delete();
        rst_n = 1'b1;
        run_xfer(8'h20, 8'h60, 8'd8, 1'b0, 8'h00, da, b1, ib);
        checks++;
        if (da !== 17) begin errors++; $display("FAIL restart_latency got=%0d want=17", da); end
        checks++;
        if (count_diffs() !== 0) begin
            errors++; $display("FAIL restart_memory got=%0d differing bytes want=0", count_diffs());
        end
    endtask

    task automatic test_start_held();
        int n_done = 0;
        int first = -1;
        int second = -1;
        logic busy6, busy7, busy12;
        @(negedge clk);
        src_addr = 8'h50; dst_addr = 8'h90; length = 8'd2; fill = 1'b0; start = 1'b1;
        push_expected(8'h50, 8'h90, 8'd2, 1'b0, 8'h00);
        push_expected(8'h50, 8'h90, 8'd2, 1'b0, 8'h00);
        wr_count = 0;
        @(posedge clk);
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (first < 0) first = i; else if (second < 0) second = i;
            end
            if (i == 6) busy6 = busy;
            if (i == 7) begin busy7 = busy; start = 1'b0; end
            if (i == 12) busy12 = busy;
        end
        checks++;
        if (n_done !== 2 || first !== 5 || second !== 11) begin
            errors++;
            $display("FAIL held_done got count=%0d at %0d,%0d want 2 at 5,11", n_done, first,
                     second);
        end
        checks++;
        if (busy6 !== 1'b0 || busy7 !== 1'b1 || busy12 !== 1'b0) begin
            errors++;
            $display("FAIL held_busy got c6=%b c7=%b c12=%b want 0 1 0", busy6, busy7, busy12);
        end
        checks++;
        if (wr_count !== 4 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL held_writes got=%0d pending=%0d want 4 0", wr_count, exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        mem[8'h10] = 8'hAA; mem[8'h11] = 8'hBB; mem[8'h12] = 8'hCC; mem[8'h13] = 8'hDD;
        ref_mem[8'h10] = 8'hAA; ref_mem[8'h11] = 8'hBB;
        ref_mem[8'h12] = 8'hCC; ref_mem[8'h13] = 8'hDD;

        test_reset();
        test_copy();
        test_zero_len();
        test_wrap();
        test_fill();
        test_overlap();
        test_reset_mid();
        test_start_held();

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
